// File: rtl/sketch_query_reader.sv
// rtl/sketch_query_reader.sv - count-min sketch query reader (per-row bucket read, min fold)
//
// Purpose:
//   Accepts one query (D row hashes + fingerprint) per handshake, issues one
//   bucket read per row to the sketch RAM, folds the returned counters into a
//   running minimum and presents the estimate on a held result port.
//
// Optional feature:
//   QUERY_FP_CHECK_EN - when defined, a row only contributes if the stored
//   fingerprint equals the query fingerprint. When undefined every row
//   contributes (plain count-min).
//
// Ports:
//   ap_clk, ap_rst_n        clock, synchronous active-low reset
//   q_valid/q_ready         query handshake; q_hash = D x 14-bit hashes, q_fp
//   mem_ce/mem_addr/mem_q   sketch RAM read port, 1-cycle read latency
//   r_valid/r_ready         result handshake; r_count estimate, r_hit flag
module sketch_query_reader #(
    parameter int D          = 3,
    parameter int BUCKET_NUM = 48,
    parameter int FP_W       = 16,
    parameter int CNT_W      = 16,
    parameter int ADDR_W     = 8
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    q_valid,
    output logic                    q_ready,
    input  logic [D*14-1:0]         q_hash,
    input  logic [FP_W-1:0]         q_fp,
    output logic                    mem_ce,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [FP_W+CNT_W-1:0]   mem_q,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [CNT_W-1:0]        r_count,
    output logic                    r_hit
);

    localparam int RW = (D < 2) ? 1 : $clog2(D + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic                q_ready_q;
    logic                mem_ce_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                r_valid_q;
    logic [CNT_W-1:0]    r_count_q;
    logic                r_hit_q;

    logic [D*14-1:0]     hash_q;
    logic [FP_W-1:0]     fp_q;
    logic [RW-1:0]       iss_q;       // next row to issue
    logic                iss_last_q;  // row currently on the RAM port is the last one
    logic                dv_q;        // mem_q carries valid row data this cycle
    logic                dlast_q;     // ... and it is the last row's data
    logic [CNT_W-1:0]    min_q;
    logic                hit_q;

    logic [CNT_W-1:0]    cnt;
    logic                fp_match;
    logic                row_qual;
    logic [CNT_W-1:0]    min_d;
    logic                hit_d;

    // Bucket address: r*BUCKET_NUM + ((h*BUCKET_NUM) >> 14). The scaled index
    // always lands below BUCKET_NUM, so rows never alias into each other.
    function automatic logic [ADDR_W-1:0] row_addr(input logic [13:0] h, input int r);
        logic [21:0] prod;
        logic [31:0] a;
        prod = {8'b0, h} * 22'(BUCKET_NUM);
        a    = 32'(r) * 32'(BUCKET_NUM) + {24'b0, prod[21:14]};
        return a[ADDR_W-1:0];
    endfunction

    assign cnt      = mem_q[CNT_W-1:0];
    assign fp_match = (mem_q[FP_W+CNT_W-1:CNT_W] == fp_q);

`ifdef QUERY_FP_CHECK_EN
    assign row_qual = fp_match;
`else
    // Fingerprint is compared but does not gate: every row qualifies.
    assign row_qual = 1'b1 | fp_match;
`endif

    always_comb begin
        min_d = min_q;
        hit_d = hit_q;
        if (row_qual) begin
            hit_d = 1'b1;
            if (cnt < min_q) begin
                min_d = cnt;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= ST_IDLE;
            q_ready_q  <= 1'b0;
            mem_ce_q   <= 1'b0;
            mem_addr_q <= '0;
            r_valid_q  <= 1'b0;
            r_count_q  <= '0;
            r_hit_q    <= 1'b0;
            hash_q     <= '0;
            fp_q       <= '0;
            iss_q      <= '0;
            iss_last_q <= 1'b0;
            dv_q       <= 1'b0;
            dlast_q    <= 1'b0;
            min_q      <= '1;
            hit_q      <= 1'b0;
        end else begin
            // Read data follows the issue by exactly one cycle.
            dv_q    <= mem_ce_q;
            dlast_q <= mem_ce_q & iss_last_q;

            case (state_q)
                ST_IDLE: begin
                    mem_ce_q   <= 1'b0;
                    mem_addr_q <= '0;
                    iss_last_q <= 1'b0;
                    q_ready_q  <= 1'b1;
                    if (q_valid && q_ready_q) begin
                        hash_q     <= q_hash;
                        fp_q       <= q_fp;
                        min_q      <= '1;
                        hit_q      <= 1'b0;
                        // Row 0 is issued straight from the input so it
                        // appears on the RAM port in the first READ cycle.
                        mem_ce_q   <= 1'b1;
                        mem_addr_q <= row_addr(q_hash[13:0], 0);
                        iss_last_q <= (D == 1);
                        iss_q      <= RW'(1);
                        q_ready_q  <= 1'b0;
                        state_q    <= ST_READ;
                    end
                end

                ST_READ: begin
                    q_ready_q <= 1'b0;
                    if (int'(iss_q) < D) begin
                        mem_ce_q   <= 1'b1;
                        mem_addr_q <= row_addr(hash_q[int'(iss_q)*14 +: 14], int'(iss_q));
                        iss_last_q <= (int'(iss_q) == D - 1);
                        iss_q      <= iss_q + RW'(1);
                    end else begin
                        mem_ce_q   <= 1'b0;
                        mem_addr_q <= '0;
                        iss_last_q <= 1'b0;
                    end

                    if (dv_q) begin
                        min_q <= min_d;
                        hit_q <= hit_d;
                        if (dlast_q) begin
                            r_valid_q <= 1'b1;
                            r_count_q <= hit_d ? min_d : '0;
                            r_hit_q   <= hit_d;
                            state_q   <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    mem_ce_q   <= 1'b0;
                    mem_addr_q <= '0;
                    iss_last_q <= 1'b0;
                    q_ready_q  <= 1'b0;
                    if (r_ready) begin
                        r_valid_q <= 1'b0;
                        r_count_q <= '0;
                        r_hit_q   <= 1'b0;
                        q_ready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign q_ready  = q_ready_q;
    assign mem_ce   = mem_ce_q;
    assign mem_addr = mem_addr_q;
    assign r_valid  = r_valid_q;
    assign r_count  = r_count_q;
    assign r_hit    = r_hit_q;

endmodule
